// File: rtl/lattice_stage_sequencer.sv
// lattice_stage_sequencer
//   Time-multiplexes one external lattice processing unit (PU) across STAGES
//   lattice stages, one stage per clock. The PU computes f = b - a*c and
//   g = a + b*c combinationally; this block owns the coefficient file, the
//   per-stage backward-delay memory and the sample handshakes.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   in_valid/in_ready     sample source handshake, in_data = x[n]
//   out_valid/out_ready   sample sink handshake, out_data = f of last stage
//   cfg_we/addr/data      coefficient write, honoured only in IDLE
//   cfg_busy              high whenever the sequencer is not IDLE
//   pu_a/pu_b/pu_coe      PU operands (zero outside RUN)
//   pu_f/pu_g             PU results, combinational from the operands
//   flush_req             clear delay memory (used only with LATTICE_FLUSH_EN)
//
// Configuration macro: LATTICE_FLUSH_EN adds the FLUSH state, which walks the
// delay memory and zeroes it. Without it flush_req is ignored.

module lattice_stage_sequencer #(
    parameter int STAGES = 8,
    parameter int DW     = 16,
    parameter int AW     = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    input  logic          cfg_we,
    input  logic [AW-1:0] cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic          cfg_busy,
    output logic [DW-1:0] pu_a,
    output logic [DW-1:0] pu_b,
    output logic [DW-1:0] pu_coe,
    input  logic [DW-1:0] pu_f,
    input  logic [DW-1:0] pu_g,
    input  logic          flush_req
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;
`ifdef LATTICE_FLUSH_EN
    localparam logic [1:0] S_FLUSH = 2'd3;
`endif

    // Storage is sized to the full address space so any k/cfg_addr value is a
    // legal index; entries at or above STAGES are never written or read.
    localparam int            DEPTH = 1 << AW;
    localparam logic [AW-1:0] LAST  = AW'(STAGES - 1);

    logic [1:0]    state;
    logic [AW-1:0] k;
    logic [DW-1:0] a;       // forward value entering the current stage
    logic [DW-1:0] gprev;   // backward value to be stored into mem[k]
    logic [DW-1:0] coef [DEPTH];
    logic [DW-1:0] mem  [DEPTH];
    logic          cfg_ok;
    logic          run;

`ifndef LATTICE_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush_req;
`endif

    assign run      = (state == S_RUN);
    assign in_ready = (state == S_IDLE);
    assign cfg_busy = (state != S_IDLE);
    assign cfg_ok   = cfg_we && (state == S_IDLE) && (int'(cfg_addr) < STAGES);

    // Operands are combinational so the PU result is available on the same
    // edge that advances the stage.
    assign pu_a   = run ? a        : '0;
    assign pu_b   = run ? mem[k]   : '0;
    assign pu_coe = run ? coef[k]  : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            a         <= '0;
            gprev     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                coef[i] <= '0;
                mem[i]  <= '0;
            end
        end else begin
            // A write in the accepting cycle lands before RUN reads coef.
            if (cfg_ok)
                coef[cfg_addr] <= cfg_data;

            case (state)
                S_IDLE: begin
`ifdef LATTICE_FLUSH_EN
                    if (flush_req) begin
                        k     <= '0;
                        state <= S_FLUSH;
                    end else
`endif
                    if (in_valid) begin
                        a     <= in_data;
                        gprev <= in_data;
                        k     <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    // mem[k] takes the backward value arriving at this stage,
                    // not this stage's g; g feeds the next stage instead.
                    mem[k] <= gprev;
                    gprev  <= pu_g;
                    a      <= pu_f;
                    if (k == LAST) begin
                        out_data  <= pu_f;
                        out_valid <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
`ifdef LATTICE_FLUSH_EN
                S_FLUSH: begin
                    mem[k] <= '0;
                    if (k == LAST)
                        state <= S_IDLE;
                    else
                        k <= k + 1'b1;
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lattice_stage_sequencer.sv
// Directed bench for lattice_stage_sequencer: three instances (STAGES = 2, 1, 8)
// each wired to a behavioural PU model f = b - a*c, g = a + b*c (mod 2^16).

module tb_lattice_stage_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic        out_ready, flush_req;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_data;

    logic        iv1, ir1, ov1, we1, busy1;
    logic        iv2, ir2, ov2, we2, busy2;
    logic        iv8, ir8, ov8, we8, busy8;
    logic [15:0] d1, od1, pa1, pb1, pc1, pf1, pg1;
    logic [15:0] d2, od2, pa2, pb2, pc2, pf2, pg2;
    logic [15:0] d8, od8, pa8, pb8, pc8, pf8, pg8;

    assign pf1 = pb1 - pa1 * pc1;
    assign pg1 = pa1 + pb1 * pc1;
    assign pf2 = pb2 - pa2 * pc2;
    assign pg2 = pa2 + pb2 * pc2;
    assign pf8 = pb8 - pa8 * pc8;
    assign pg8 = pa8 + pb8 * pc8;

    lattice_stage_sequencer #(.STAGES(1), .DW(16), .AW(3)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .in_data(d1),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1),
        .cfg_we(we1), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(busy1),
        .pu_a(pa1), .pu_b(pb1), .pu_coe(pc1), .pu_f(pf1), .pu_g(pg1),
        .flush_req(flush_req));

    lattice_stage_sequencer #(.STAGES(2), .DW(16), .AW(3)) u2 (
        .clk(clk), .reset(reset), .in_valid(iv2), .in_ready(ir2), .in_data(d2),
        .out_valid(ov2), .out_ready(out_ready), .out_data(od2),
        .cfg_we(we2), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(busy2),
        .pu_a(pa2), .pu_b(pb2), .pu_coe(pc2), .pu_f(pf2), .pu_g(pg2),
        .flush_req(flush_req));

    lattice_stage_sequencer #(.STAGES(8), .DW(16), .AW(3)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .in_data(d8),
        .out_valid(ov8), .out_ready(out_ready), .out_data(od8),
        .cfg_we(we8), .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_busy(busy8),
        .pu_a(pa8), .pu_b(pb8), .pu_coe(pc8), .pu_f(pf8), .pu_g(pg8),
        .flush_req(flush_req));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Waits (bounded) on negedges until u2 presents an output.
    task automatic wait_ov2();
        for (int i = 0; i < 20 && !ov2; i++) @(negedge clk);
        chk("ov2_timeout", 32'(ov2), 1);
    endtask

    initial begin
        out_ready = 1'b1; flush_req = 1'b0; cfg_addr = '0; cfg_data = '0;
        iv1 = 0; iv2 = 0; iv8 = 0; we1 = 0; we2 = 0; we8 = 0;
        d1 = '0; d2 = '0; d8 = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(ir2), 1);
        chk("rst_out_valid", 32'(ov2), 0);
        chk("rst_out_data", 32'(od2), 0);
        chk("rst_cfg_busy", 32'(busy2), 0);
        chk("rst_pu_a", 32'(pa2), 0);
        reset = 1'b1;

        // STAGES=2, coef 0: pure delay, 5 -> 0
        @(negedge clk); iv2 = 1; d2 = 16'd5;
        @(negedge clk); iv2 = 0;
        chk("run_pu_a", 32'(pa2), 5);
        chk("run_busy", 32'(busy2), 1);
        chk("run_in_ready", 32'(ir2), 0);
        wait_ov2();
        chk("delay_out0", 32'(od2), 0);
        @(negedge clk);
        chk("hs_out_valid", 32'(ov2), 0);
        chk("hs_in_ready", 32'(ir2), 1);

        // 7 -> 5, with 5 cycles of backpressure
        out_ready = 1'b0;
        iv2 = 1; d2 = 16'd7;
        @(negedge clk); iv2 = 0;
        wait_ov2();
        chk("delay_out1", 32'(od2), 5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_data_%0d", i), 32'(od2), 5);
            chk($sformatf("bp_valid_%0d", i), 32'(ov2), 1);
            chk($sformatf("bp_in_ready_%0d", i), 32'(ir2), 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_valid", 32'(ov2), 0);
        chk("bp_release_ready", 32'(ir2), 1);

        // Flush request, then rerun 5
        flush_req = 1'b1;
        @(negedge clk); flush_req = 1'b0;
`ifdef LATTICE_FLUSH_EN
        chk("flush_busy", 32'(busy2), 1);
        chk("flush_in_ready", 32'(ir2), 0);
`else
        chk("noflush_in_ready", 32'(ir2), 1);
        chk("noflush_busy", 32'(busy2), 0);
`endif
        for (int i = 0; i < 20 && !ir2; i++) @(negedge clk);
        chk("flush_timeout", 32'(ir2), 1);
        iv2 = 1; d2 = 16'd5;
        @(negedge clk); iv2 = 0;
        // cfg write during RUN must be dropped
        we2 = 1; cfg_addr = 3'd0; cfg_data = 16'd9;
        chk("rerun_coe0", 32'(pc2), 0);
        @(negedge clk); we2 = 0;
        wait_ov2();
`ifdef LATTICE_FLUSH_EN
        chk("rerun_out", 32'(od2), 0);
`else
        chk("rerun_out", 32'(od2), 7);
`endif
        @(negedge clk);

        // Out-of-range address write in IDLE has no effect
        we2 = 1; cfg_addr = 3'd2; cfg_data = 16'd9;
        @(negedge clk); we2 = 0;
        iv2 = 1; d2 = 16'd1;
        @(negedge clk); iv2 = 0;
        chk("drop_coe_s0", 32'(pc2), 0);
        @(negedge clk);
        chk("drop_coe_s1", 32'(pc2), 0);
        wait_ov2();
        chk("drop_out", 32'(od2), 5);
        @(negedge clk);

        // STAGES=1, coef written in the same cycle the sample is accepted
        we1 = 1; cfg_addr = 3'd0; cfg_data = 16'd2; iv1 = 1; d1 = 16'd3;
        @(negedge clk); we1 = 0; iv1 = 0;
        chk("s1_coe", 32'(pc1), 2);
        @(negedge clk);
        chk("s1_valid0", 32'(ov1), 1);
        chk("s1_out0", 32'(od1), 16'hFFFA);
        @(negedge clk);
        iv1 = 1; d1 = 16'd1;
        @(negedge clk); iv1 = 0;
        @(negedge clk);
        chk("s1_valid1", 32'(ov1), 1);
        chk("s1_out1", 32'(od1), 16'h0001);
        @(negedge clk);

        // STAGES=8 latency
        iv8 = 1; d8 = 16'd4;
        @(negedge clk); iv8 = 0;
        for (int i = 0; i <= 8; i++) begin
            chk($sformatf("lat_valid_%0d", i), 32'(ov8), 32'(i == 8));
            chk($sformatf("lat_in_ready_%0d", i), 32'(ir8), 0);
            @(negedge clk);
        end
        chk("lat_ready_back", 32'(ir8), 1);
        chk("lat_valid_clear", 32'(ov8), 0);

        // Reset mid-RUN discards the sample and clears memory
        iv2 = 1; d2 = 16'd3;
        @(negedge clk); iv2 = 0;
        reset = 1'b0;
        @(negedge clk); reset = 1'b1;
        chk("midrst_in_ready", 32'(ir2), 1);
        chk("midrst_busy", 32'(busy2), 0);
        chk("midrst_valid", 32'(ov2), 0);
        iv2 = 1; d2 = 16'd5;
        @(negedge clk); iv2 = 0;
        wait_ov2();
        chk("midrst_out", 32'(od2), 0);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
